vga_frame_capture: RTL

//  Receive end of the 640x480@60Hz VGA stream produced by the display driver.
//  - Recovers pixel position from the HSync, VSync and Blank_n signals.
//  - Decimates 2:1 in both axes and emits draw-point writes (X, Y, RGB12) for a 320x240 frame buffer.
//  - Checks line/frame geometry; used for loopback capture and self-test of the display path.

---
 rtl/vga_frame_capture.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: recovers pixel position from a VGA stream and emits 2:1 decimated frame-buffer writes.
// Latency: 2 clocks from pins to Update/X/Y/Rgb; frame status pulses 1 clock after a VSync fall is seen.
// Backpressure: none; the stream is free-running and every output is a single-cycle strobe.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1Enable,
  input  logic        piul1HSync,
  input  logic        piul1VSync,
  input  logic        piul1Blank_n,
  input  logic [7:0]  piul8Red,
  input  logic [7:0]  piul8Green,
  input  logic [7:0]  piul8Blue,
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb,
  output logic        poul1Update,
  output logic        poul1FrameDone,
  output logic        poul1LineErr,
  output logic        poul1FrameErr,
  output logic [15:0] poul16FrameCnt
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

  state_t      state;

  // Input stage (S1) and previous-sample stage (S2) used for edge detection
  logic        en_s1, hs_s1, vs_s1, bl_s1;
  logic [11:0] rgb_s1;
  logic        hs_s2, vs_s2, bl_s2;

  // Position counters and frame bookkeeping
  logic [10:0] col;
  logic [9:0]  line;
  logic        dirty;

  // The 12-bit output format keeps only the colour high nibbles
  logic [11:0] unused_lsb;
  assign unused_lsb = {piul8Red[3:0], piul8Green[3:0], piul8Blue[3:0]};

  logic        vs_fall, hs_fall, bl_fall, line_end, capturing;
  logic [10:0] col_sat_inc, col_next;
  logic [9:0]  line_sat_inc, line_next;
  logic        lerr_now, dirty_next, pix_ok;

  assign vs_fall   = vs_s2 & ~vs_s1;
  assign hs_fall   = hs_s2 & ~hs_s1;
  assign bl_fall   = bl_s2 & ~bl_s1;
  // An HSync fall while still in active video also terminates the line
  assign line_end  = bl_fall | (hs_fall & bl_s1);
  assign capturing = (state == CAPTURE);

  assign col_sat_inc  = (col == 11'h7FF) ? col : col + 11'd1;
  assign line_sat_inc = (line == 10'h3FF) ? line : line + 10'd1;
  assign col_next     = hs_fall ? 11'd0 : (bl_s1 ? col_sat_inc : col);
  // Line count as seen after this cycle's line end, so a coincident frame close sees it
  assign line_next    = (line_end && (col != 11'd0)) ? line_sat_inc : line;
  assign lerr_now     = capturing & line_end & (col != H_LIM);
  assign dirty_next   = dirty | lerr_now;
  assign pix_ok       = capturing & bl_s1 & ~col[0] & ~line[0] & (col < H_LIM) & (line < V_LIM);

  // Register the pins once, then keep one older copy of the control lines for edge detection
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      en_s1  <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
      bl_s1  <= 1'b0;
      rgb_s1 <= 12'd0;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
      bl_s2  <= 1'b0;
    end else begin
      en_s1  <= piul1Enable;
      hs_s1  <= piul1HSync;
      vs_s1  <= piul1VSync;
      bl_s1  <= piul1Blank_n;
      rgb_s1 <= {piul8Red[7:4], piul8Green[7:4], piul8Blue[7:4]};
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      bl_s2  <= bl_s1;
    end
  end

  // Capture FSM: position counters, draw-point writes and line/frame checks with registered outputs
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state          <= IDLE;
      col            <= 11'd0;
      line           <= 10'd0;
      dirty          <= 1'b0;
      poul9PosX      <= 9'd0;
      poul9PosY      <= 9'd0;
      poul12Rgb      <= 12'd0;
      poul1Update    <= 1'b0;
      poul1FrameDone <= 1'b0;
      poul1LineErr   <= 1'b0;
      poul1FrameErr  <= 1'b0;
      poul16FrameCnt <= 16'd0;
    end else begin
      poul1Update    <= 1'b0;
      poul1FrameDone <= 1'b0;
      poul1FrameErr  <= 1'b0;
      poul1LineErr   <= lerr_now;
      if (pix_ok) begin
        poul1Update <= 1'b1;
        poul9PosX   <= col[9:1];
        poul9PosY   <= line[9:1];
        poul12Rgb   <= rgb_s1;
      end
      case (state)
        IDLE: begin
          if (vs_fall) begin
            state <= en_s1 ? CAPTURE : SKIP;
            col   <= 11'd0;
            line  <= 10'd0;
            dirty <= 1'b0;
          end
        end
        default: begin
          if (vs_fall) begin
            if (capturing) begin
              if (line_next != V_LIM) begin
                poul1FrameErr <= 1'b1;
              end else if (!dirty_next) begin
                poul1FrameDone <= 1'b1;
                poul16FrameCnt <= poul16FrameCnt + 16'd1;
              end
            end
            state <= en_s1 ? CAPTURE : SKIP;
            col   <= 11'd0;
            line  <= 10'd0;
            dirty <= 1'b0;
          end else begin
            col   <= col_next;
            line  <= line_next;
            dirty <= dirty_next;
          end
        end
      endcase
    end
  end

endmodule
